// File: rtl/norm_ctrl.sv
// Job controller for a row-normalisation unit: latches per-job configuration,
// issues rows under a credit limit and tracks returns to detect job completion.
module norm_ctrl #(
    parameter int unsigned DWIDTH          = 8,
    parameter int unsigned MASK_WIDTH      = 16,
    parameter int unsigned CNT_WIDTH       = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cfg_enable_norm,
    input  logic [DWIDTH-1:0]     cfg_mean,
    input  logic [DWIDTH-1:0]     cfg_inv_var,
    input  logic [MASK_WIDTH-1:0] cfg_mask,
    input  logic [CNT_WIDTH-1:0]  cfg_num_rows,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  enable_norm,
    output logic [DWIDTH-1:0]     mean,
    output logic [DWIDTH-1:0]     inv_var,
    output logic [MASK_WIDTH-1:0] validity_mask,
    output logic                  in_data_available,
    input  logic                  out_data_available,
    output logic                  busy,
    output logic                  done_norm,
    output logic                  err,
    output logic [3:0]            outstanding
);

    localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic                  enable_norm_q, enable_norm_d;
    logic [DWIDTH-1:0]     mean_q, mean_d;
    logic [DWIDTH-1:0]     inv_var_q, inv_var_d;
    logic [MASK_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]  num_rows_q, num_rows_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [CNT_WIDTH-1:0]  returned_q, returned_d;
    logic [3:0]            outstanding_q, outstanding_d;
    logic                  err_q, err_d;

    logic issue;
    logic ret_window;
    logic ret_ok;
    logic ret_bad;

    // Issue handshake and return classification
    always_comb begin
        // Gated by reset so the norm unit never sees a row the controller forgets.
        src_ready  = (state_q == StRun) && (issued_q < num_rows_q) &&
                     (outstanding_q < MaxOut) && !reset;
        issue      = src_valid && src_ready;
        ret_window = (state_q == StRun) || (state_q == StDrain) || (state_q == StDone);
        ret_ok     = out_data_available && ret_window && (outstanding_q != 4'd0) &&
                     (returned_q != num_rows_q);
        ret_bad    = out_data_available && !ret_ok;
    end

    // Next-state, configuration latch and credit counters
    always_comb begin
        state_d       = state_q;
        enable_norm_d = enable_norm_q;
        mean_d        = mean_q;
        inv_var_d     = inv_var_q;
        mask_d        = mask_q;
        num_rows_d    = num_rows_q;
        issued_d      = issued_q + CNT_WIDTH'(issue);
        returned_d    = returned_q + CNT_WIDTH'(ret_ok);
        err_d         = err_q | ret_bad;
        outstanding_d = outstanding_q;
        if (issue && !ret_ok) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (ret_ok && !issue) begin
            outstanding_d = outstanding_q - 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    enable_norm_d = cfg_enable_norm;
                    mean_d        = cfg_mean;
                    inv_var_d     = cfg_inv_var;
                    mask_d        = cfg_mask;
                    num_rows_d    = cfg_num_rows;
                    issued_d      = '0;
                    returned_d    = '0;
                    // A spurious return in the start cycle still flags.
                    err_d         = ret_bad;
                    state_d       = (cfg_num_rows != '0) ? StLoad : StDone;
                end
            end
            StLoad:  state_d = StRun;
            StRun: begin
                if (issued_d == num_rows_q) state_d = StDrain;
            end
            StDrain: begin
                if (returned_d == num_rows_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            enable_norm_q <= 1'b0;
            mean_q        <= '0;
            inv_var_q     <= '0;
            mask_q        <= '0;
            num_rows_q    <= '0;
            issued_q      <= '0;
            returned_q    <= '0;
            outstanding_q <= 4'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_norm_q <= enable_norm_d;
            mean_q        <= mean_d;
            inv_var_q     <= inv_var_d;
            mask_q        <= mask_d;
            num_rows_q    <= num_rows_d;
            issued_q      <= issued_d;
            returned_q    <= returned_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Output drive from state and latched registers
    always_comb begin
        in_data_available = issue;
        enable_norm       = enable_norm_q;
        mean              = mean_q;
        inv_var           = inv_var_q;
        validity_mask     = mask_q;
        busy              = (state_q != StIdle);
        done_norm         = (state_q == StDone);
        err               = err_q;
        outstanding       = outstanding_q;
    end

endmodule

// File: tb/tb_norm_ctrl.sv
// Directed bench for norm_ctrl: a delay-line model of the norm unit returns each
// issued row a fixed number of cycles later, and per-job statistics are checked.
module tb_norm_ctrl;

    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        reset, start, cfg_enable_norm;
    logic [7:0]  cfg_mean, cfg_inv_var, cfg_num_rows;
    logic [15:0] cfg_mask;
    logic        src_valid, src_ready, enable_norm, in_data_available, out_data_available;
    logic [7:0]  mean, inv_var;
    logic [15:0] validity_mask;
    logic        busy, done_norm, err;
    logic [3:0]  outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    bit iss [0:1023];
    int s_iss, s_ret, s_max, s_done, s_lag, s_busy, s_full_ready;
    int s_same_seen, s_same_bad, s_cfg_bad;
    logic s_load_ready, s_load_err;
    bit s_timeout;

    norm_ctrl #(
        .DWIDTH(8), .MASK_WIDTH(16), .CNT_WIDTH(8), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_enable_norm(cfg_enable_norm),
        .cfg_mean(cfg_mean), .cfg_inv_var(cfg_inv_var), .cfg_mask(cfg_mask),
        .cfg_num_rows(cfg_num_rows), .src_valid(src_valid), .src_ready(src_ready),
        .enable_norm(enable_norm), .mean(mean), .inv_var(inv_var),
        .validity_mask(validity_mask), .in_data_available(in_data_available),
        .out_data_available(out_data_available), .busy(busy), .done_norm(done_norm),
        .err(err), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    // Runs one job; t=0 is the cycle after the start edge. Inputs change at negedge.
    task automatic run_job(input int rows, input int lat, input logic en, input logic [7:0] m,
                           input logic [7:0] iv, input logic [15:0] mk, input bit poke);
        int t, done_t, last_ret;
        bit pend_same, odav_now;
        s_iss = 0; s_ret = 0; s_max = 0; s_done = 0; s_busy = 0; s_full_ready = 0;
        s_same_seen = 0; s_same_bad = 0; s_cfg_bad = 0; done_t = -1; last_ret = -1;
        pend_same = 0;
        @(negedge clk);
        start = 1'b1; cfg_enable_norm = en; cfg_mean = m; cfg_inv_var = iv; cfg_mask = mk;
        cfg_num_rows = rows[7:0];
        @(negedge clk);
        start = 1'b0;
        // Scramble config inputs so held outputs must come from the latch.
        cfg_enable_norm = ~en; cfg_mean = ~m; cfg_inv_var = ~iv; cfg_mask = ~mk;
        for (t = 0; t < 300; t++) begin
            odav_now = (t >= lat) && iss[t - lat];
            out_data_available = odav_now;
            src_valid = 1'b1;
            start = poke && (t == 3);
            #1;
            iss[t] = in_data_available;
            if (pend_same && outstanding !== 4'd2) s_same_bad++;
            pend_same = in_data_available && odav_now && (outstanding === 4'd2);
            if (pend_same) s_same_seen++;
            if (t == 0) begin s_load_ready = src_ready; s_load_err = err; end
            if (enable_norm !== en || mean !== m || inv_var !== iv || validity_mask !== mk)
                s_cfg_bad++;
            if (src_ready && int'(outstanding) >= MO) s_full_ready++;
            if (int'(outstanding) > s_max) s_max = int'(outstanding);
            if (busy) s_busy++;
            if (in_data_available) s_iss++;
            if (odav_now) begin s_ret++; last_ret = t; end
            if (done_norm === 1'b1) begin s_done++; if (done_t < 0) done_t = t; end
            if (done_t >= 0 && t >= done_t + 2) break;
            @(negedge clk);
        end
        s_timeout = (done_t < 0);
        s_lag = (done_t >= 0) ? done_t - last_ret : -1;
        out_data_available = 1'b0; src_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; src_valid = 1'b1; out_data_available = 1'b0;
        cfg_enable_norm = 1'b1; cfg_mean = 8'hFF; cfg_inv_var = 8'hFF; cfg_mask = 16'hFFFF;
        cfg_num_rows = 8'd5;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({src_ready, in_data_available, busy, done_norm, err, enable_norm} !== 6'b0 ||
            outstanding !== 4'd0 || mean !== 8'd0 || inv_var !== 8'd0 ||
            validity_mask !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ida=%b busy=%b done=%b err=%b out=%0d mean=%h, want all 0",
                     src_ready, in_data_available, busy, done_norm, err, outstanding, mean);
        end
        src_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_job(3, 2, 1'b1, 8'h10, 8'h02, 16'hFFFF, 1'b0);
        n_tests++; if (s_timeout) begin n_fail++; $display("FAIL basic_timeout: done never seen, want done"); end
        n_tests++; if (s_load_ready !== 1'b0) begin n_fail++; $display("FAIL basic_load_ready: got %b want 0", s_load_ready); end
        n_tests++; if (s_iss != 3) begin n_fail++; $display("FAIL basic_issues: got %0d want 3", s_iss); end
        n_tests++; if (s_max != 2) begin n_fail++; $display("FAIL basic_peak: got %0d want 2", s_max); end
        n_tests++; if (s_done != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", s_done); end
        n_tests++; if (s_lag != 1) begin n_fail++; $display("FAIL basic_done_lag: got %0d want 1", s_lag); end
        n_tests++; if (s_busy != 7) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 7", s_busy); end
        n_tests++; if (s_cfg_bad != 0) begin n_fail++; $display("FAIL basic_cfg_hold: got %0d bad cycles want 0", s_cfg_bad); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
    endtask

    task automatic test_credit_limit();
        run_job(10, 8, 1'b0, 8'hA5, 8'h3C, 16'h00F0, 1'b0);
        n_tests++; if (s_timeout) begin n_fail++; $display("FAIL credit_timeout: done never seen, want done"); end
        n_tests++; if (s_max != 4) begin n_fail++; $display("FAIL credit_peak: got %0d want 4", s_max); end
        n_tests++; if (s_full_ready != 0) begin n_fail++; $display("FAIL credit_ready_full: got %0d want 0", s_full_ready); end
        n_tests++; if (s_iss != 10 || s_ret != 10) begin n_fail++; $display("FAIL credit_counts: got iss=%0d ret=%0d want 10/10", s_iss, s_ret); end
        n_tests++; if (s_done != 1 || s_lag != 1) begin n_fail++; $display("FAIL credit_done: got cnt=%0d lag=%0d want 1/1", s_done, s_lag); end
        n_tests++; if (s_cfg_bad != 0) begin n_fail++; $display("FAIL credit_cfg_hold: got %0d bad cycles want 0", s_cfg_bad); end
    endtask

    task automatic test_zero_rows();
        run_job(0, 2, 1'b1, 8'h01, 8'h02, 16'h0003, 1'b0);
        n_tests++; if (s_busy != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 1", s_busy); end
        n_tests++; if (s_done != 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d want 1", s_done); end
        n_tests++; if (s_iss != 0) begin n_fail++; $display("FAIL zero_issues: got %0d want 0", s_iss); end
    endtask

    task automatic test_back_to_back();
        // Latency 2 keeps outstanding at 2 while issue and return coincide.
        run_job(5, 2, 1'b1, 8'h33, 8'h44, 16'h5555, 1'b1);
        n_tests++; if (s_same_seen == 0) begin n_fail++; $display("FAIL b2b_same_seen: got 0 coincident cycles want >0"); end
        n_tests++; if (s_same_bad != 0) begin n_fail++; $display("FAIL b2b_same_hold: got %0d bad cycles want 0", s_same_bad); end
        n_tests++; if (s_cfg_bad != 0) begin n_fail++; $display("FAIL b2b_restart_ignored: got %0d bad cycles want 0", s_cfg_bad); end
        n_tests++; if (s_iss != 5 || s_done != 1) begin n_fail++; $display("FAIL b2b_counts: got iss=%0d done=%0d want 5/1", s_iss, s_done); end
    endtask

    task automatic test_spurious();
        @(negedge clk); out_data_available = 1'b1;
        @(negedge clk); out_data_available = 1'b0; #1;
        n_tests++; if (err !== 1'b1 || outstanding !== 4'd0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL spur_idle: got err=%b out=%0d busy=%b want 1/0/0", err, outstanding, busy); end
        run_job(2, 3, 1'b1, 8'h77, 8'h11, 16'h8001, 1'b0);
        n_tests++; if (s_load_err !== 1'b0) begin n_fail++; $display("FAIL spur_err_clear: got %b want 0", s_load_err); end
        n_tests++; if (s_iss != 2 || s_done != 1 || err !== 1'b0) begin n_fail++;
            $display("FAIL spur_next_job: got iss=%0d done=%0d err=%b want 2/1/0", s_iss, s_done, err); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start = 1'b1; cfg_enable_norm = 1'b1; cfg_mean = 8'h5A; cfg_inv_var = 8'hC3;
        cfg_mask = 16'h0FF0; cfg_num_rows = 8'd6;
        @(negedge clk); start = 1'b0;          // LOAD
        @(negedge clk); src_valid = 1'b1;      // RUN, issue 1
        @(negedge clk);                        // issue 2
        @(negedge clk); src_valid = 1'b0; #1;
        n_tests++; if (outstanding !== 4'd2 || busy !== 1'b1) begin n_fail++;
            $display("FAIL mrst_pre: got out=%0d busy=%b want 2/1", outstanding, busy); end
        @(negedge clk); reset = 1'b1; src_valid = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        n_tests++;
        if ({src_ready, in_data_available, busy, done_norm, err, enable_norm} !== 6'b0 ||
            outstanding !== 4'd0 || mean !== 8'd0 || inv_var !== 8'd0 ||
            validity_mask !== 16'd0) begin
            n_fail++;
            $display("FAIL mrst_outputs: got rdy=%b ida=%b busy=%b out=%0d mean=%h, want all 0",
                     src_ready, in_data_available, busy, outstanding, mean);
        end
        src_valid = 1'b0;
        @(negedge clk); out_data_available = 1'b1;   // late return of a forgotten row
        @(negedge clk); out_data_available = 1'b0; #1;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL mrst_late_return: got err=%b want 1", err); end
        run_job(3, 2, 1'b1, 8'h10, 8'h02, 16'hFFFF, 1'b0);
        n_tests++; if (s_timeout || s_iss != 3 || s_done != 1 || s_max != 2) begin n_fail++;
            $display("FAIL mrst_next_job: got iss=%0d done=%0d peak=%0d want 3/1/2", s_iss, s_done, s_max); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit_limit();
        test_zero_rows();
        test_back_to_back();
        test_spurious();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
